pipe_regs: RTL and testbench

PIPE_REGS -- requirements
Module: pipe_regs

---
 rtl/pipe_regs_if.sv | 35 +++
 rtl/pipe_regs.sv | 79 +++++++
 tb/tb_pipe_regs.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_regs_if.sv
// Bundle of pipeline-register control inputs, stage buses and registered outputs.
// The master drives stage results and control; the slave (pipe_regs) returns the registers.
interface pipe_regs_if;
  logic         F_stall;
  logic         D_stall;
  logic         D_bubble;
  logic         E_bubble;
  logic         setcc;
  logic [63:0]  f_predPC;
  logic [147:0] f_bus;
  logic [219:0] d_bus;
  logic [144:0] e_bus;
  logic [143:0] m_bus;
  logic [2:0]   e_cc;

  logic [63:0]  F_predPC;
  logic [147:0] D_reg;
  logic [219:0] E_reg;
  logic [144:0] M_reg;
  logic [143:0] W_reg;
  logic [2:0]   cc;
  logic         halted;

  modport master (
    output F_stall, D_stall, D_bubble, E_bubble, setcc,
           f_predPC, f_bus, d_bus, e_bus, m_bus, e_cc,
    input  F_predPC, D_reg, E_reg, M_reg, W_reg, cc, halted
  );

  modport slave (
    input  F_stall, D_stall, D_bubble, E_bubble, setcc,
           f_predPC, f_bus, d_bus, e_bus, m_bus, e_cc,
    output F_predPC, D_reg, E_reg, M_reg, W_reg, cc, halted
  );
endinterface

// File: rtl/pipe_regs.sv
// Y86-style F/D/E/M/W pipeline registers with stall/bubble control, condition
// codes and a sticky halt that freezes everything once a bad status retires.
module pipe_regs (
  input  logic        clk,
  input  logic        rst,
  pipe_regs_if.slave  pif
);
  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] ICODE_OPQ = 4'h6;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [147:0] BUB_D = {STAT_AOK, ICODE_NOP, 4'h0, REG_NONE, REG_NONE, 64'd0, 64'd0};
  localparam logic [219:0] BUB_E = {STAT_AOK, ICODE_NOP, 4'h0, 64'd0, 64'd0, 64'd0,
                                    REG_NONE, REG_NONE, REG_NONE, REG_NONE};
  localparam logic [144:0] BUB_M = {STAT_AOK, ICODE_NOP, 1'b0, 64'd0, 64'd0, REG_NONE, REG_NONE};
  localparam logic [143:0] BUB_W = {STAT_AOK, ICODE_NOP, 64'd0, 64'd0, REG_NONE, REG_NONE};

  logic [63:0]  r_f_pred_pc;
  logic [147:0] r_d;
  logic [219:0] r_e;
  logic [144:0] r_m;
  logic [143:0] r_w;
  logic [2:0]   r_cc;
  logic         r_halted;

  logic [3:0] w_e_icode;
  logic [3:0] w_w_stat;
  logic       w_run;

  assign w_e_icode = r_e[215:212];
  assign w_w_stat  = r_w[143:140];
  // Gating uses the registered flag, so the edge that sets halt still updates normally.
  assign w_run     = ~r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_pred_pc <= 64'd0;
      r_d         <= BUB_D;
      r_e         <= BUB_E;
      r_m         <= BUB_M;
      r_w         <= BUB_W;
      r_cc        <= 3'b100;
      r_halted    <= 1'b0;
    end else if (w_run) begin
      if (!pif.F_stall)
        r_f_pred_pc <= pif.f_predPC;

      if (!pif.D_stall) begin
        if (pif.D_bubble)
          r_d <= BUB_D;
        else
          r_d <= pif.f_bus;
      end

      if (pif.E_bubble)
        r_e <= BUB_E;
      else
        r_e <= pif.d_bus;

      r_m <= pif.e_bus;
      r_w <= pif.m_bus;

      if (pif.setcc && (w_e_icode == ICODE_OPQ))
        r_cc <= pif.e_cc;

      if (w_w_stat != STAT_AOK)
        r_halted <= 1'b1;
    end
  end

  assign pif.F_predPC = r_f_pred_pc;
  assign pif.D_reg    = r_d;
  assign pif.E_reg    = r_e;
  assign pif.M_reg    = r_m;
  assign pif.W_reg    = r_w;
  assign pif.cc       = r_cc;
  assign pif.halted   = r_halted;
endmodule

// File: tb/tb_pipe_regs.sv
// Scoreboard bench for pipe_regs: a behavioural model predicts every register
// each cycle; directed sections cover reset, load-use, mispredict, CC and halt.
module tb_pipe_regs;
  logic clk;
  logic rst;
  pipe_regs_if pif ();

  pipe_regs dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [147:0] BUB_D = {4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 128'd0};
  localparam logic [219:0] BUB_E = {4'b1000, 4'h1, 4'h0, 192'd0, 16'hFFFF};
  localparam logic [144:0] BUB_M = {4'b1000, 4'h1, 1'b0, 128'd0, 8'hFF};
  localparam logic [143:0] BUB_W = {4'b1000, 4'h1, 128'd0, 8'hFF};

  typedef struct packed {
    logic [63:0]  f;
    logic [147:0] d;
    logic [219:0] e;
    logic [144:0] m;
    logic [143:0] w;
    logic [2:0]   cc;
    logic         h;
  } st_t;

  st_t mdl;
  st_t sb[$];
  int  n_cmp;
  int  n_err;

  task automatic chk(input string tag, input logic [219:0] got, input logic [219:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic st_t reset_state();
    st_t s;
    s.f = 64'd0; s.d = BUB_D; s.e = BUB_E; s.m = BUB_M; s.w = BUB_W;
    s.cc = 3'b100; s.h = 1'b0;
    return s;
  endfunction

  task automatic chk_all(input string pfx, input st_t s);
    chk({pfx, "_F"},  220'(pif.F_predPC), 220'(s.f));
    chk({pfx, "_D"},  220'(pif.D_reg),    220'(s.d));
    chk({pfx, "_E"},  pif.E_reg,          s.e);
    chk({pfx, "_M"},  220'(pif.M_reg),    220'(s.m));
    chk({pfx, "_W"},  220'(pif.W_reg),    220'(s.w));
    chk({pfx, "_cc"}, 220'(pif.cc),       220'(s.cc));
    chk({pfx, "_h"},  220'(pif.halted),   220'(s.h));
  endtask

  // Predict next register values from the current inputs, advance one edge, compare.
  task automatic step(input string tag);
    st_t n;
    n = mdl;
    if (!mdl.h) begin
      if (!pif.F_stall) n.f = pif.f_predPC;
      if (pif.D_stall)       n.d = mdl.d;
      else if (pif.D_bubble) n.d = BUB_D;
      else                   n.d = pif.f_bus;
      n.e = pif.E_bubble ? BUB_E : pif.d_bus;
      n.m = pif.e_bus;
      n.w = pif.m_bus;
      if (pif.setcc && mdl.e[215:212] == 4'h6) n.cc = pif.e_cc;
      if (mdl.w[143:140] != 4'b1000) n.h = 1'b1;
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
    n = sb.pop_front();
    chk_all(tag, n);
    mdl = n;
  endtask

  function automatic logic [223:0] rnd224();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_ctl();
    pif.F_stall = 0; pif.D_stall = 0; pif.D_bubble = 0; pif.E_bubble = 0; pif.setcc = 0;
  endtask

  task automatic rnd_inputs();
    logic [223:0] r;
    logic [219:0] d;
    logic [143:0] m;
    pif.F_stall  = ($urandom_range(0, 3) == 0);
    pif.D_stall  = ($urandom_range(0, 3) == 0);
    pif.D_bubble = ($urandom_range(0, 3) == 0);
    pif.E_bubble = ($urandom_range(0, 3) == 0);
    pif.setcc    = ($urandom_range(0, 1) == 0);
    pif.e_cc     = 3'($urandom);
    pif.f_predPC = {$urandom, $urandom};
    r = rnd224(); pif.f_bus = r[147:0];
    r = rnd224(); d = r[219:0];
    if ($urandom_range(0, 1) == 0) d[215:212] = 4'h6;
    pif.d_bus = d;
    r = rnd224(); pif.e_bus = r[144:0];
    r = rnd224(); m = r[143:0];
    m[143:140] = 4'b1000;
    pif.m_bus = m;
  endtask

  task automatic reset_check(input string tag);
    st_t rs;
    rs = reset_state();
    rst = 1'b1;
    #2;
    chk_all({tag, "_now"}, rs);
    @(posedge clk); #1;
    chk_all({tag, "_held"}, rs);
    @(negedge clk);
    rst = 1'b0;
    mdl = rs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]  sv_f;
    logic [147:0] sv_d;
    logic [144:0] sv_eb;
    logic [219:0] dd;
    logic [143:0] mm;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    clear_ctl();
    pif.e_cc = 3'b000;
    pif.f_predPC = 64'd0;
    pif.f_bus = BUB_D; pif.d_bus = BUB_E; pif.e_bus = BUB_M; pif.m_bus = BUB_W;
    mdl = reset_state();
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst0", mdl);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rnd_inputs();
      step("rnd");
    end

    // Load-use: hold F and D, bubble E.
    rnd_inputs();
    clear_ctl();
    step("pre_lu");
    sv_f = pif.F_predPC; sv_d = pif.D_reg; sv_eb = pif.e_bus;
    pif.E_bubble = 1; pif.D_stall = 1; pif.F_stall = 1;
    pif.f_predPC = 64'h40;
    step("lu");
    chk("lu_F", 220'(pif.F_predPC), 220'(sv_f));
    chk("lu_D", 220'(pif.D_reg), 220'(sv_d));
    chk("lu_E_icode", 220'(pif.E_reg[215:212]), 220'(4'h1));
    chk("lu_E_dst", 220'(pif.E_reg[15:8]), 220'(8'hFF));
    chk("lu_M", 220'(pif.M_reg), 220'(sv_eb));

    // Mispredict: both D and E squashed, F still loads.
    clear_ctl();
    pif.D_bubble = 1; pif.E_bubble = 1;
    dd = pif.d_bus; dd[215:212] = 4'h6; pif.d_bus = dd;
    pif.f_predPC = 64'h1234_5678_9ABC_DEF0;
    step("mp");
    chk("mp_D", 220'(pif.D_reg), 220'(BUB_D));
    chk("mp_E", pif.E_reg, BUB_E);
    chk("mp_F", 220'(pif.F_predPC), 220'(64'h1234_5678_9ABC_DEF0));

    // Stall beats bubble on D.
    clear_ctl();
    pif.f_bus = 148'h5A5A;
    step("pr_load");
    sv_d = pif.D_reg;
    pif.D_stall = 1; pif.D_bubble = 1; pif.f_bus = 148'h77;
    step("pr");
    chk("pr_D", 220'(pif.D_reg), 220'(sv_d));

    // CC gating.
    clear_ctl();
    dd = pif.d_bus; dd[215:212] = 4'h6; pif.d_bus = dd;
    step("cc_ld");
    pif.setcc = 1; pif.e_cc = 3'b011;
    step("cc_set");
    chk("cc_set", 220'(pif.cc), 220'(3'b011));
    pif.setcc = 0; pif.e_cc = 3'b101;
    dd[215:212] = 4'h2; pif.d_bus = dd;
    step("cc_off");
    chk("cc_off", 220'(pif.cc), 220'(3'b011));
    pif.setcc = 1; pif.e_cc = 3'b110;
    step("cc_icode2");
    chk("cc_icode2", 220'(pif.cc), 220'(3'b011));

    // Halt on bad status reaching W.
    clear_ctl();
    mm = pif.m_bus; mm[143:140] = 4'b0100; pif.m_bus = mm;
    step("hlt_w");
    chk("hlt_wstat", 220'(pif.W_reg[143:140]), 220'(4'b0100));
    chk("hlt_not_yet", 220'(pif.halted), 220'(1'b0));
    rnd_inputs();
    step("hlt_set");
    chk("hlt_set", 220'(pif.halted), 220'(1'b1));
    sv_f = pif.F_predPC;
    for (int i = 0; i < 5; i++) begin
      rnd_inputs();
      pif.f_predPC = pif.f_predPC ^ 64'h1;
      step("hlt_hold");
    end
    chk("hlt_F_frozen", 220'(pif.F_predPC), 220'(sv_f));

    // Reset mid-halt, mid-stall.
    pif.F_stall = 1; pif.D_stall = 1;
    reset_check("rst_mid");
    clear_ctl();
    for (int i = 0; i < 10; i++) begin
      rnd_inputs();
      step("post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
